// File: rtl/display_scan.sv
// Scan timing for the 7-segment driver: digit select, per-digit enables with
// an anti-ghosting blanking window, blink phase and leading-zero suppression.
`timescale 1ns/1ps
module display_scan #(
   parameter int SCAN_DIV     = 1000,
   parameter int BLANK_CYCLES = 16,
   parameter int BLINK_FRAMES = 125
) (
   input  logic       i_Clk,
   input  logic       i_Rst_n,
   input  logic       i_Display_On,
   input  logic [3:0] i_Blink_Mask,
   input  logic       i_Dot_En,
   input  logic       i_Dot_Blink,
   input  logic       i_Blink_Restart,
   input  logic       i_LZ_Suppress,
   input  logic [3:0] i_Tens_Hour,
   output logic [1:0] o_Select,
   output logic [3:0] o_Enable_Digits,
   output logic       o_Enable_Dot,
   output logic       o_Blink_Phase,
   output logic       o_Frame_Tick
);

   localparam int DIV_W   = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam int BLINK_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

   localparam logic [DIV_W-1:0]   DIV_LOAD   = DIV_W'(SCAN_DIV - 1);
   localparam logic [DIV_W-1:0]   BLANK_EDGE = DIV_W'(SCAN_DIV - 1 - BLANK_CYCLES);
   localparam logic [BLINK_W-1:0] BLINK_LOAD = BLINK_W'(BLINK_FRAMES - 1);

   // Both timers are down-counters; slot position = DIV_LOAD - div_cnt.
   logic [DIV_W-1:0]   div_cnt, div_nxt;
   logic [BLINK_W-1:0] blink_cnt, blink_nxt;
   logic [1:0]         sel_nxt;
   logic               slot_wrap, frame_wrap;
   logic               phase_nxt, blank_nxt, lz;
   logic [3:0]         en_nxt;
   logic               dot_nxt;

   always_comb begin
      slot_wrap  = (div_cnt == '0);
      div_nxt    = slot_wrap ? DIV_LOAD : div_cnt - 1'b1;
      sel_nxt    = slot_wrap ? o_Select + 2'd1 : o_Select;
      frame_wrap = slot_wrap && (o_Select == 2'd3);

      blink_nxt = blink_cnt;
      phase_nxt = o_Blink_Phase;
      // Restart wins over a coincident frame boundary.
      if (i_Blink_Restart) begin
         blink_nxt = BLINK_LOAD;
         phase_nxt = 1'b0;
      end else if (frame_wrap) begin
         if (blink_cnt == '0) begin
            blink_nxt = BLINK_LOAD;
            phase_nxt = ~o_Blink_Phase;
         end else begin
            blink_nxt = blink_cnt - 1'b1;
         end
      end

      // Outputs are computed from next-state values so they line up with the
      // counter state registered alongside them.
      blank_nxt = (div_nxt > BLANK_EDGE);
      lz        = i_LZ_Suppress && (i_Tens_Hour == 4'd0);
      en_nxt    = {4{i_Display_On & ~blank_nxt}}
                & ~(i_Blink_Mask & {4{phase_nxt}})
                & ~{lz, 3'b000};
      dot_nxt   = i_Display_On & i_Dot_En & ~(i_Dot_Blink & phase_nxt);
   end

   always_ff @(posedge i_Clk or negedge i_Rst_n) begin
      if (!i_Rst_n) begin
         div_cnt         <= DIV_LOAD;
         blink_cnt       <= BLINK_LOAD;
         o_Select        <= 2'd0;
         o_Blink_Phase   <= 1'b0;
         o_Enable_Digits <= 4'd0;
         o_Enable_Dot    <= 1'b0;
         o_Frame_Tick    <= 1'b0;
      end else begin
         div_cnt         <= div_nxt;
         blink_cnt       <= blink_nxt;
         o_Select        <= sel_nxt;
         o_Blink_Phase   <= phase_nxt;
         o_Enable_Digits <= en_nxt;
         o_Enable_Dot    <= dot_nxt;
         o_Frame_Tick    <= frame_wrap;
      end
   end

endmodule

// File: doc/display_scan.md
Name: display_scan

Overview:
- Timing and sequencing source for the 7-segment display driver: generates the digit select, the per-digit enable mask and the dot enable that the driver consumes.
- Provides multiplex scanning with an anti-ghosting blanking window at each digit slot, blink phase generation for setting modes, and optional leading-zero suppression of the tens-of-hours digit.
- Sits between the control unit (mode/blink requests) and the display driver.

Parameters:
- SCAN_DIV, 1000: clock cycles per digit slot; must be >= 2.
- BLANK_CYCLES, 16: cycles at the start of each slot during which all digits are disabled; must be < SCAN_DIV.
- BLINK_FRAMES, 125: complete 4-digit frames per blink half-period; must be >= 1.

Ports:
- i_Clk  input  1  system clock.
- i_Rst_n  input  1  asynchronous active-low reset.
- i_Display_On  input  1  master display enable.
- i_Blink_Mask  input  4  digits to blink; [3]=Dig1 (tens hour) … [0]=Dig4 (units min).
- i_Dot_En  input  1  dot requested.
- i_Dot_Blink  input  1  dot blinks with blink phase.
- i_Blink_Restart  input  1  single-cycle pulse: restart blink in visible phase.
- i_LZ_Suppress  input  1  enable leading-zero suppression.
- i_Tens_Hour  input  4  current tens-of-hours BCD value.
- o_Select  output  2  digit select: 00=Dig1 … 11=Dig4.
- o_Enable_Digits  output  4  digit enable mask, same bit order as i_Blink_Mask.
- o_Enable_Dot  output  1  dot enable.
- o_Blink_Phase  output  1  0=visible, 1=hidden.
- o_Frame_Tick  output  1  one-cycle pulse per completed frame.

Behaviour:
- Reset: async on i_Rst_n low, with no clock required. Clears the divider, o_Select=00, blink counter=0, o_Blink_Phase=0, o_Enable_Digits=0000, o_Enable_Dot=0, o_Frame_Tick=0.
- Divider r_Div counts 0..SCAN_DIV-1 and wraps. On each wrap, o_Select increments modulo 4 (11→00).
- o_Frame_Tick=1 for exactly the cycle in which o_Select has just become 00 through a wrap. It is not asserted at reset release.
- Blink counter: increments on each o_Frame_Tick and counts 0..BLINK_FRAMES-1. On wrap, o_Blink_Phase toggles.
- i_Blink_Restart: clears the blink counter and forces o_Blink_Phase=0 on the next edge.
  - This has priority over a simultaneous frame tick or toggle.
  - The divider and select are unaffected.
- All outputs are registered, and every output is consistent with the counter state held in the same cycle.
- Blanking: blank=1 when r_Div < BLANK_CYCLES.
- Enable bit k = i_Display_On & ~blank & ~(i_Blink_Mask[k] & o_Blink_Phase) & ~lz_k, where lz_k=1 only for k=3 with i_LZ_Suppress=1 and i_Tens_Hour==0.
- o_Enable_Dot = i_Display_On & i_Dot_En & ~(i_Dot_Blink & o_Blink_Phase). The dot is not blanked; the driver gates it by select position.
- Inputs are sampled every edge. A change to a mask, LZ or dot input appears on outputs the cycle after it is sampled.
- With i_Display_On=0, counters, select, phase and frame tick keep running while enables and dot are 0. Re-enabling requires no resynchronisation.
- Counter widths come from $clog2 of the parameters, and there is no overflow beyond the wrap values.

Test Plan:
All scenarios use SCAN_DIV=8, BLANK_CYCLES=2, BLINK_FRAMES=2.
- Release reset with Display_On=1 and masks 0 → o_Select steps 00,01,10,11 every 8 cycles. Enables are 0000 for cycles 0–1 of each slot and 1111 for cycles 2–7. o_Frame_Tick pulses once at cycle 32, then every 32 cycles.
- i_Blink_Mask=1100 → o_Blink_Phase rises after the 2nd frame tick (cycle 64). Non-blank enables are 0011 while the phase is 1 and 1111 after the phase returns to 0 at cycle 128.
- i_LZ_Suppress=1 with i_Tens_Hour=0 → non-blank enables 0111. With i_Tens_Hour=1 → 1111. With i_LZ_Suppress=0 and i_Tens_Hour=0 → 1111.
- Pulse i_Blink_Restart while the phase is 1, coincident with a frame tick → next cycle phase=0 and counter=0. The next toggle occurs exactly 2 frame ticks later.
- Assert i_Rst_n low at slot 2, cycle 5, with clock stopped → outputs immediately read select=00, enables 0000, dot 0, phase 0. After release, scanning restarts from slot 0, cycle 0.
- i_Display_On=0 with i_Dot_En=1 → enables 0000 and dot 0 while o_Select keeps stepping. On re-enable, enables return in the next non-blank cycle.
